// File: rtl/uart_lite_pkg.sv
// Shared definitions for the UART Lite sequencer: native register map, STAT/CTRL bit
// positions and the controller state encoding.
package uart_lite_pkg;

   localparam logic [3:0] ADDR_RX   = 4'h0;
   localparam logic [3:0] ADDR_TX   = 4'h4;
   localparam logic [3:0] ADDR_STAT = 4'h8;
   localparam logic [3:0] ADDR_CTRL = 4'hC;

   localparam int STAT_RX_VALID = 0;
   localparam int STAT_TX_FULL  = 3;
   localparam int STAT_OVERRUN  = 5;
   localparam int STAT_PARITY   = 7;

   localparam int CTRL_RST_TX = 0;
   localparam int CTRL_RST_RX = 1;

   // Flush both UART FIFOs, leave interrupts disabled
   localparam logic [31:0] CTRL_INIT = (32'd1 << CTRL_RST_TX) | (32'd1 << CTRL_RST_RX);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_POLL,
      ST_RD_RX,
      ST_WR_TX,
      ST_GAP
   } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO used as the local RX byte buffer; DEPTH must be a power of two
// so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
   assign do_push = push_i && (!full_o || pop_i);
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_lite_ctrl.sv
// Sequencer in front of the UART Lite native register port: pushes user bytes into TX,
// drains RX into a local FIFO by polling STAT, and keeps sticky error flags.
module uart_lite_ctrl
   import uart_lite_pkg::*;
#(
   parameter int POLL_GAP = 4,
   parameter int TIMEOUT  = 1024,
   parameter int RX_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        tx_valid_i,
   input  logic [7:0]  tx_data_i,
   output logic        tx_ready_o,
   output logic        rx_valid_o,
   output logic [7:0]  rx_data_o,
   input  logic        rx_ready_i,
   output logic [5:0]  status_o,
   input  logic        clear_i,
   output logic        wr_valid_o,
   output logic [3:0]  wr_addr_o,
   output logic [31:0] wr_data_o,
   input  logic        wr_ready_i,
   input  logic        wr_err_i,
   output logic [3:0]  rd_addr_o,
   output logic        rd_ready_o,
   input  logic        rd_valid_i,
   input  logic [31:0] rd_data_i,
   input  logic        rd_err_i
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
   localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

   state_e        state_q;
   logic          wr_valid_q;
   logic [3:0]    wr_addr_q;
   logic [31:0]   wr_data_q;
   logic          rd_ready_q;
   logic [3:0]    rd_addr_q;
   logic [7:0]    hold_q;
   logic          hold_full_q;
   logic          last_rx_q;
   logic [TW-1:0] to_cnt_q;
   logic [GW-1:0] gap_cnt_q;
   logic [5:0]    status_q;
   logic [5:0]    status_d;
   logic [5:0]    status_set;

   logic       wr_done;
   logic       rd_done;
   logic       outstanding;
   logic       stat_ok;
   logic       rx_ok;
   logic       tx_ok;
   logic       tx_accept;
   logic       fifo_push;
   logic       fifo_pop;
   logic       fifo_empty;
   logic       fifo_full;
   logic [7:0] fifo_dout;
   logic       unused_rd_bits;

   assign wr_done     = wr_valid_q && wr_ready_i;
   assign rd_done     = rd_ready_q && rd_valid_i;
   assign outstanding = wr_valid_q || rd_ready_q;
   // An errored STAT read carries no trustworthy flags, so it is treated as "nothing to do"
   assign stat_ok     = rd_done && !rd_err_i && (state_q == ST_POLL);
   assign rx_ok       = stat_ok && rd_data_i[STAT_RX_VALID] && !fifo_full;
   assign tx_ok       = stat_ok && hold_full_q && !rd_data_i[STAT_TX_FULL];
   assign tx_ready_o  = !hold_full_q && (state_q != ST_INIT);
   assign tx_accept   = tx_valid_i && tx_ready_o;
   assign fifo_push   = rd_done && !rd_err_i && (state_q == ST_RD_RX);
   assign fifo_pop    = !fifo_empty && rx_ready_i;

   assign unused_rd_bits = ^rd_data_i[31:8];

   always_comb begin
      status_set = '0;
      if (stat_ok) begin
         status_set[2:0] = rd_data_i[STAT_PARITY:STAT_OVERRUN];
      end
      status_set[3] = wr_done && wr_err_i;
      status_set[4] = rd_done && rd_err_i;
      status_set[5] = outstanding && (to_cnt_q == TO_MAX);
      status_d = (clear_i ? 6'b0 : status_q) | status_set;
   end

   // One request at a time: each state raises its request on entry and leaves on completion
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_INIT;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_ready_q  <= 1'b0;
         rd_addr_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         last_rx_q   <= 1'b0;
         to_cnt_q    <= '0;
         gap_cnt_q   <= '0;
         status_q    <= '0;
      end else begin
         status_q <= status_d;
         if (outstanding && (to_cnt_q != TO_MAX)) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
         if (tx_accept) begin
            hold_q      <= tx_data_i;
            hold_full_q <= 1'b1;
         end
         unique case (state_q)
            ST_INIT: begin
               if (!wr_valid_q) begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= ADDR_CTRL;
                  wr_data_q  <= CTRL_INIT;
                  to_cnt_q   <= '0;
               end else if (wr_ready_i) begin
                  wr_valid_q <= 1'b0;
                  state_q    <= ST_POLL;
               end
            end
            ST_POLL: begin
               if (!rd_ready_q) begin
                  rd_ready_q <= 1'b1;
                  rd_addr_q  <= ADDR_STAT;
                  to_cnt_q   <= '0;
               end else if (rd_valid_i) begin
                  rd_ready_q <= 1'b0;
                  if (rx_ok && (!tx_ok || !last_rx_q)) begin
                     state_q   <= ST_RD_RX;
                     last_rx_q <= 1'b1;
                  end else if (tx_ok) begin
                     state_q   <= ST_WR_TX;
                     last_rx_q <= 1'b0;
                  end else begin
                     state_q   <= ST_GAP;
                     gap_cnt_q <= '0;
                  end
               end
            end
            ST_RD_RX: begin
               if (!rd_ready_q) begin
                  rd_ready_q <= 1'b1;
                  rd_addr_q  <= ADDR_RX;
                  to_cnt_q   <= '0;
               end else if (rd_valid_i) begin
                  rd_ready_q <= 1'b0;
                  state_q    <= ST_POLL;
               end
            end
            ST_WR_TX: begin
               if (!wr_valid_q) begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= ADDR_TX;
                  wr_data_q  <= {24'h0, hold_q};
                  to_cnt_q   <= '0;
               end else if (wr_ready_i) begin
                  wr_valid_q  <= 1'b0;
                  hold_full_q <= 1'b0;
                  state_q     <= ST_POLL;
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_q <= ST_POLL;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (rd_data_i[7:0]),
      .pop_i   (fifo_pop),
      .data_o  (fifo_dout),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign rx_valid_o = !fifo_empty;
   assign rx_data_o  = fifo_dout;
   assign status_o   = status_q;
   assign wr_valid_o = wr_valid_q;
   assign wr_addr_o  = wr_addr_q;
   assign wr_data_o  = wr_data_q;
   assign rd_ready_o = rd_ready_q;
   assign rd_addr_o  = rd_addr_q;

endmodule

// File: tb/tb_uart_lite_ctrl.sv
// Directed bench for uart_lite_ctrl: the initial block plays both the user and the
// native bridge, answering each request by hand with known STAT/RX values.
module tb_uart_lite_ctrl;

   localparam int POLL_GAP = 4;
   localparam int TIMEOUT  = 1024;
   localparam int RX_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        tx_valid_i;
   logic [7:0]  tx_data_i;
   logic        tx_ready_o;
   logic        rx_valid_o;
   logic [7:0]  rx_data_o;
   logic        rx_ready_i;
   logic [5:0]  status_o;
   logic        clear_i;
   logic        wr_valid_o;
   logic [3:0]  wr_addr_o;
   logic [31:0] wr_data_o;
   logic        wr_ready_i;
   logic        wr_err_i;
   logic [3:0]  rd_addr_o;
   logic        rd_ready_o;
   logic        rd_valid_i;
   logic [31:0] rd_data_i;
   logic        rd_err_i;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_lite_ctrl #(
      .POLL_GAP (POLL_GAP),
      .TIMEOUT  (TIMEOUT),
      .RX_DEPTH (RX_DEPTH)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .tx_valid_i (tx_valid_i),
      .tx_data_i  (tx_data_i),
      .tx_ready_o (tx_ready_o),
      .rx_valid_o (rx_valid_o),
      .rx_data_o  (rx_data_o),
      .rx_ready_i (rx_ready_i),
      .status_o   (status_o),
      .clear_i    (clear_i),
      .wr_valid_o (wr_valid_o),
      .wr_addr_o  (wr_addr_o),
      .wr_data_o  (wr_data_o),
      .wr_ready_i (wr_ready_i),
      .wr_err_i   (wr_err_i),
      .rd_addr_o  (rd_addr_o),
      .rd_ready_o (rd_ready_o),
      .rd_valid_i (rd_valid_i),
      .rd_data_i  (rd_data_i),
      .rd_err_i   (rd_err_i)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   // Wait (bounded) for a native write, check it, then complete it after 'delay' cycles
   task automatic expectWrite(input string tag, input logic [3:0] addr, input logic [31:0] data,
                              input int delay, input logic err);
      int n = 0;
      while (!wr_valid_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_req"}, {31'b0, wr_valid_o}, 32'd1);
      if (!wr_valid_o) return;
      checkOutput({tag, "_addr"}, {28'b0, wr_addr_o}, {28'b0, addr});
      checkOutput({tag, "_data"}, wr_data_o, data);
      checkOutput({tag, "_no_rd"}, {31'b0, rd_ready_o}, 32'd0);
      repeat (delay) @(negedge clk);
      wr_ready_i = 1'b1;
      wr_err_i   = err;
      @(negedge clk);
      wr_ready_i = 1'b0;
      wr_err_i   = 1'b0;
   endtask

   // Wait (bounded) for a native read, check it, then answer after 'delay' cycles
   task automatic expectRead(input string tag, input logic [3:0] addr, input logic [31:0] data,
                             input int delay, input logic err);
      int n = 0;
      while (!rd_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_req"}, {31'b0, rd_ready_o}, 32'd1);
      if (!rd_ready_o) return;
      checkOutput({tag, "_addr"}, {28'b0, rd_addr_o}, {28'b0, addr});
      checkOutput({tag, "_no_wr"}, {31'b0, wr_valid_o}, 32'd0);
      repeat (delay) @(negedge clk);
      rd_valid_i = 1'b1;
      rd_data_i  = data;
      rd_err_i   = err;
      @(negedge clk);
      rd_valid_i = 1'b0;
      rd_data_i  = '0;
      rd_err_i   = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      tx_valid_i = 1'b1;
      tx_data_i  = b;
      @(negedge clk);
      tx_valid_i = 1'b0;
   endtask

   task automatic popByte(input string tag, input logic [7:0] b);
      checkOutput({tag, "_valid"}, {31'b0, rx_valid_o}, 32'd1);
      checkOutput({tag, "_data"}, {24'b0, rx_data_o}, {24'b0, b});
      rx_ready_i = 1'b1;
      @(negedge clk);
      rx_ready_i = 1'b0;
   endtask

   initial begin
      int idle;
      rst_i      = 1'b1;
      tx_valid_i = 1'b0;
      tx_data_i  = '0;
      rx_ready_i = 1'b0;
      clear_i    = 1'b0;
      wr_ready_i = 1'b0;
      wr_err_i   = 1'b0;
      rd_valid_i = 1'b0;
      rd_data_i  = '0;
      rd_err_i   = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rst_wr_valid", {31'b0, wr_valid_o}, 32'd0);
      checkOutput("rst_rd_ready", {31'b0, rd_ready_o}, 32'd0);
      checkOutput("rst_tx_ready", {31'b0, tx_ready_o}, 32'd0);
      checkOutput("rst_rx_valid", {31'b0, rx_valid_o}, 32'd0);
      checkOutput("rst_status", {26'b0, status_o}, 32'd0);
      rst_i = 1'b0;

      // Init write to CTRL, then polling starts
      expectWrite("init", 4'hC, 32'h0000_0003, 0, 1'b0);
      checkOutput("init_tx_ready", {31'b0, tx_ready_o}, 32'd1);

      // One received byte
      expectRead("stat1", 4'h8, 32'h01, 0, 1'b0);
      expectRead("rx41", 4'h0, 32'h41, 0, 1'b0);
      popByte("pop41", 8'h41);
      checkOutput("pop41_empty", {31'b0, rx_valid_o}, 32'd0);

      // One transmitted byte
      applyStimulus(8'h5A);
      checkOutput("hold_busy", {31'b0, tx_ready_o}, 32'd0);
      expectRead("stat2", 4'h8, 32'h00, 0, 1'b0);
      expectWrite("tx5a", 4'h4, 32'h0000_005A, 0, 1'b0);
      checkOutput("tx5a_ready", {31'b0, tx_ready_o}, 32'd1);

      // RX and TX both serviceable: alternate, RX first since TX was served last
      applyStimulus(8'h11);
      expectRead("alt_s1", 4'h8, 32'h01, 0, 1'b0);
      expectRead("alt_rx1", 4'h0, 32'h61, 0, 1'b0);
      expectRead("alt_s2", 4'h8, 32'h01, 0, 1'b0);
      expectWrite("alt_tx1", 4'h4, 32'h0000_0011, 0, 1'b0);
      applyStimulus(8'h22);
      expectRead("alt_s3", 4'h8, 32'h01, 0, 1'b0);
      expectRead("alt_rx2", 4'h0, 32'h62, 0, 1'b0);
      expectRead("alt_s4", 4'h8, 32'h01, 0, 1'b0);
      expectWrite("alt_tx2", 4'h4, 32'h0000_0022, 0, 1'b0);
      popByte("pop61", 8'h61);
      popByte("pop62", 8'h62);
      checkOutput("alt_empty", {31'b0, rx_valid_o}, 32'd0);

      // Five bytes waiting, no user pops: four reads fill the FIFO, then only polls
      for (int i = 0; i < 4; i++) begin
         expectRead("fill_stat", 4'h8, 32'h01, 0, 1'b0);
         expectRead("fill_rx", 4'h0, 32'h70 + 32'(i), 0, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         expectRead("full_stat", 4'h8, 32'h01, 0, 1'b0);
         idle = 0;
         while (!rd_ready_o && idle < 100) begin
            checkOutput("full_no_wr", {31'b0, wr_valid_o}, 32'd0);
            @(negedge clk);
            idle++;
         end
         checkOutput("full_gap", {31'b0, (idle >= POLL_GAP && idle < 100)}, 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
         popByte("drain", 8'h70 + 8'(i));
      end
      checkOutput("drain_empty", {31'b0, rx_valid_o}, 32'd0);
      expectRead("fifth_stat", 4'h8, 32'h01, 0, 1'b0);
      expectRead("fifth_rx", 4'h0, 32'h74, 0, 1'b0);
      popByte("pop74", 8'h74);
      checkOutput("status_clean", {26'b0, status_o}, 32'd0);

      // Overrun, then an RX read that stalls past the timeout and returns an error
      expectRead("ovr_stat", 4'h8, 32'h21, 0, 1'b0);
      expectRead("err_rx", 4'h0, 32'h99, 1100, 1'b1);
      checkOutput("err_status", {26'b0, status_o}, 32'b110001);
      checkOutput("err_no_push", {31'b0, rx_valid_o}, 32'd0);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      checkOutput("cleared", {26'b0, status_o}, 32'd0);

      // Set wins over clear in the same cycle
      clear_i = 1'b1;
      expectRead("par_stat", 4'h8, 32'h80, 0, 1'b0);
      clear_i = 1'b0;
      checkOutput("set_over_clear", {26'b0, status_o}, 32'b000100);

      // Write error still empties the holding register
      applyStimulus(8'h33);
      expectRead("we_stat", 4'h8, 32'h00, 0, 1'b0);
      expectWrite("we_tx", 4'h4, 32'h0000_0033, 0, 1'b1);
      checkOutput("we_status", {26'b0, status_o}, 32'b001100);
      checkOutput("we_tx_ready", {31'b0, tx_ready_o}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
